id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard detection built in.
- Captures decoded control and operand data from the ID stage.
- Detects load-use hazards against the instruction currently held in EX. When one is found it stalls PC and IF/ID, gates the ID control unit through `ctrl_enable`, and inserts a bubble.
- Also accepts a flush (taken branch/jump) and a debug halt.

Parameters:
- DATA_W, 32, operand/PC width
- REG_W, 5, register address width
- ALU_OP_W, 4, alu_op width from the control unit
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- halt  in  1  debug freeze; holds all state
- flush  in  1  taken branch/jump; squash the ID instruction
- id_branch, id_is_beq, id_reg_dest, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_jump  in  1 each  control from ID
- id_alu_op  in  ALU_OP_W  ALU op class
- id_pc_plus4, id_rs_data, id_rt_data, id_imm  in  DATA_W each  PC+4, register operands, sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_W each  register addresses
- id_funct  in  6  function field
- ex_* (same set and widths as the id_* inputs)  out  registered copies
- pc_write  out  1  0 = hold PC
- if_id_write  out  1  0 = hold IF/ID
- ctrl_enable  out  1  drives the control unit `enable`
- stall_count  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst_n=0, async):
  - all ex_* = 0, which is a bubble.
  - stall_count = 0.
  - pc_write, if_id_write and ctrl_enable are combinational and read as 1, because no hazard can exist with ex_mem_read=0.
- Hazard detect (combinational, from registered EX state):
  - hazard = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
  - uses_rt = ~id_alu_src | id_mem_write.
  - hazard is masked when halt=1.
- Stall outputs:
  - pc_write = if_id_write = ctrl_enable = ~hazard & ~halt.
  - flush does not affect these outputs.
- Register update each posedge, first match wins:
  - halt=1: all ex_* and stall_count hold.
  - flush=1: load bubble (all ex_* control bits = 0, alu_op = 0; data fields may also clear to 0).
  - hazard=1: load bubble; stall_count += 1, saturating at all-ones.
  - otherwise: ex_* <= id_*.
- Latency: 1 cycle from ID to EX.
- Load-use sequence: an lw followed by a dependent instruction stalls exactly one cycle.
  - The cycle after the bubble, ex_mem_read = 0, so hazard drops and the held ID instruction advances.
- flush and hazard together: the bubble is loaded once; stall_count increments only when hazard=1 and flush=0.
- Back-to-back loads into the same rt: each dependent consumer stalls one cycle independently.
- Reset mid-stall: the bubble state clears and the held ID instruction proceeds after reset is released.

Decomposition:
- Shared package `mips_pkg`:
  - DATA_W, REG_W, ALU_OP_W
  - the alu_op class encodings (R-type 0000, BEQ 0001, BNE 0011, J 0100, JAL 0101, LOAD 0110, STORE 0111, ADDI..SLTIU 1000-1111)
  - a packed control-bundle struct used by both the control unit and this stage
- One natural sub-module: `hazard_detect` (the combinational hazard equation and stall outputs). The register bank stays in id_ex_stage.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all ex_* = 0 immediately, stall_count = 0; pc_write = if_id_write = ctrl_enable = 1.
- Pass-through: ID add r3,r1,r2 (reg_dest=1, reg_write=1, rs=1, rt=2, rd=3) -> next cycle ex_rd=3, ex_reg_write=1, ex_alu_op=0000; no stall.
- Load-use on rs: EX holds lw r5 (ex_mem_read=1, ex_rt=5), ID has rs=5 -> pc_write = if_id_write = ctrl_enable = 0 that cycle; next cycle EX is a bubble (ex_reg_write=0), stall_count=1; following cycle the instruction enters EX.
- rt-use filter: EX holds lw r5; ID is addi rt=5, alu_src=1 -> no stall. ID is sw with rt=5 -> stall. EX holds lw r0 with ID rs=0 -> no stall.
- Flush and hazard together: flush=1 while hazard=1 -> bubble loaded, stall_count unchanged; flush alone with ID beq -> ex_branch=0.
- Halt: with a valid instruction in EX, assert halt for 3 cycles -> ex_* and stall_count frozen, pc_write=0; on release, normal flow resumes. Force stall_count to all-ones, trigger a hazard -> count stays at all-ones.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: widths, alu_op classes and the
// decoded control bundle carried from ID into EX.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_RTYPE = 4'b0000,
        ALU_BEQ   = 4'b0001,
        ALU_BNE   = 4'b0011,
        ALU_J     = 4'b0100,
        ALU_JAL   = 4'b0101,
        ALU_LOAD  = 4'b0110,
        ALU_STORE = 4'b0111,
        ALU_ADDI  = 4'b1000,
        ALU_ADDIU = 4'b1001,
        ALU_ANDI  = 4'b1010,
        ALU_ORI   = 4'b1011,
        ALU_XORI  = 4'b1100,
        ALU_LUI   = 4'b1101,
        ALU_SLTI  = 4'b1110,
        ALU_SLTIU = 4'b1111
    } alu_op_e;

    typedef struct packed {
        logic                branch;
        logic                is_beq;
        logic                reg_dest;
        logic                alu_src;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                reg_write;
        logic                jump;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    // All-zero control is a bubble: no write-back, no memory access, no branch.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection against the load currently in EX, plus the
// resulting PC / IF-ID / control-unit enables.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             halt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_alu_src,
    input  logic             id_mem_write,
    output logic             hazard,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             ctrl_enable
);

    logic uses_rt;
    logic advance;

    // rt is a source for R-type ops (alu_src=0) and as store data for sw.
    assign uses_rt = ~id_alu_src | id_mem_write;

    assign hazard = ~halt & ex_mem_read & (ex_rt != '0)
                  & ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));

    assign advance     = ~hazard & ~halt;
    assign pc_write    = advance;
    assign if_id_write = advance;
    assign ctrl_enable = advance;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with built-in load-use stall, flush-to-bubble,
// debug halt and a saturating stall-cycle counter.
module id_ex_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                halt,
    input  logic                flush,
    input  logic                id_branch,
    input  logic                id_is_beq,
    input  logic                id_reg_dest,
    input  logic                id_alu_src,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_mem_to_reg,
    input  logic                id_reg_write,
    input  logic                id_jump,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [DATA_W-1:0]   id_pc_plus4,
    input  logic [DATA_W-1:0]   id_rs_data,
    input  logic [DATA_W-1:0]   id_rt_data,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    id_rd,
    input  logic [5:0]          id_funct,
    output logic                ex_branch,
    output logic                ex_is_beq,
    output logic                ex_reg_dest,
    output logic                ex_alu_src,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_mem_to_reg,
    output logic                ex_reg_write,
    output logic                ex_jump,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [DATA_W-1:0]   ex_pc_plus4,
    output logic [DATA_W-1:0]   ex_rs_data,
    output logic [DATA_W-1:0]   ex_rt_data,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [REG_W-1:0]    ex_rs,
    output logic [REG_W-1:0]    ex_rt,
    output logic [REG_W-1:0]    ex_rd,
    output logic [5:0]          ex_funct,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                ctrl_enable,
    output logic [CNT_W-1:0]    stall_count
);

    import mips_pkg::ctrl_t;
    import mips_pkg::CTRL_BUBBLE;

    typedef struct packed {
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [5:0]        funct;
    } opnd_t;

    ctrl_t            id_ctrl, ctrl_reg, ctrl_next;
    opnd_t            id_opnd, opnd_reg, opnd_next;
    logic [CNT_W-1:0] stall_count_reg, stall_count_next;
    logic             hazard;

    assign id_ctrl = '{branch: id_branch, is_beq: id_is_beq, reg_dest: id_reg_dest,
                       alu_src: id_alu_src, mem_read: id_mem_read, mem_write: id_mem_write,
                       mem_to_reg: id_mem_to_reg, reg_write: id_reg_write, jump: id_jump,
                       alu_op: id_alu_op};
    assign id_opnd = '{pc_plus4: id_pc_plus4, rs_data: id_rs_data, rt_data: id_rt_data,
                       imm: id_imm, rs: id_rs, rt: id_rt, rd: id_rd, funct: id_funct};

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .halt         (halt),
        .ex_mem_read  (ctrl_reg.mem_read),
        .ex_rt        (opnd_reg.rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_alu_src   (id_alu_src),
        .id_mem_write (id_mem_write),
        .hazard       (hazard),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .ctrl_enable  (ctrl_enable)
    );

    // Priority: halt freezes everything, then flush, then load-use bubble.
    always_comb begin
        ctrl_next        = ctrl_reg;
        opnd_next        = opnd_reg;
        stall_count_next = stall_count_reg;
        if (!halt) begin
            if (flush || hazard) begin
                ctrl_next = CTRL_BUBBLE;
                opnd_next = '0;
            end else begin
                ctrl_next = id_ctrl;
                opnd_next = id_opnd;
            end
            if (hazard && !flush && (stall_count_reg != {CNT_W{1'b1}}))
                stall_count_next = stall_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg        <= CTRL_BUBBLE;
            opnd_reg        <= '0;
            stall_count_reg <= '0;
        end else begin
            ctrl_reg        <= ctrl_next;
            opnd_reg        <= opnd_next;
            stall_count_reg <= stall_count_next;
        end
    end

    assign ex_branch     = ctrl_reg.branch;
    assign ex_is_beq     = ctrl_reg.is_beq;
    assign ex_reg_dest   = ctrl_reg.reg_dest;
    assign ex_alu_src    = ctrl_reg.alu_src;
    assign ex_mem_read   = ctrl_reg.mem_read;
    assign ex_mem_write  = ctrl_reg.mem_write;
    assign ex_mem_to_reg = ctrl_reg.mem_to_reg;
    assign ex_reg_write  = ctrl_reg.reg_write;
    assign ex_jump       = ctrl_reg.jump;
    assign ex_alu_op     = ctrl_reg.alu_op;
    assign ex_pc_plus4   = opnd_reg.pc_plus4;
    assign ex_rs_data    = opnd_reg.rs_data;
    assign ex_rt_data    = opnd_reg.rt_data;
    assign ex_imm        = opnd_reg.imm;
    assign ex_rs         = opnd_reg.rs;
    assign ex_rt         = opnd_reg.rt;
    assign ex_rd         = opnd_reg.rd;
    assign ex_funct      = opnd_reg.funct;
    assign stall_count   = stall_count_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use stalls, flush,
// halt and stall-counter saturation (counter narrowed to 4 bits).
module tb_id_ex_stage;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n, halt, flush;
    logic id_branch, id_is_beq, id_reg_dest, id_alu_src, id_mem_read;
    logic id_mem_write, id_mem_to_reg, id_reg_write, id_jump;
    logic [3:0]  id_alu_op;
    logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic ex_branch, ex_is_beq, ex_reg_dest, ex_alu_src, ex_mem_read;
    logic ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_jump;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_funct;
    logic pc_write, if_id_write, ctrl_enable;
    logic [CNT_W-1:0] stall_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_W(5), .ALU_OP_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt), .flush(flush),
        .id_branch(id_branch), .id_is_beq(id_is_beq), .id_reg_dest(id_reg_dest),
        .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write), .id_jump(id_jump),
        .id_alu_op(id_alu_op), .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_funct(id_funct),
        .ex_branch(ex_branch), .ex_is_beq(ex_is_beq), .ex_reg_dest(ex_reg_dest),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_jump(ex_jump),
        .ex_alu_op(ex_alu_op), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_funct(ex_funct),
        .pc_write(pc_write), .if_id_write(if_id_write), .ctrl_enable(ctrl_enable),
        .stall_count(stall_count)
    );

    task automatic clear_id;
        {id_branch, id_is_beq, id_reg_dest, id_alu_src, id_mem_read} = '0;
        {id_mem_write, id_mem_to_reg, id_reg_write, id_jump} = '0;
        id_alu_op = '0; id_pc_plus4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_funct = '0;
    endtask

    task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
        clear_id;
        id_rs = rs; id_rt = rt; id_alu_src = 1'b1; id_mem_read = 1'b1;
        id_mem_to_reg = 1'b1; id_reg_write = 1'b1; id_alu_op = 4'b0110; id_imm = 32'd4;
    endtask

    task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clear_id;
        id_rs = rs; id_rt = rt; id_rd = rd; id_reg_dest = 1'b1; id_reg_write = 1'b1;
        id_funct = 6'h20;
    endtask

    task automatic test_reset;
        @(negedge clk);
        set_rtype(5'd1, 5'd2, 5'd3);
        id_rs_data = 32'hAAAA_0001; id_pc_plus4 = 32'h0000_0040;
        @(posedge clk); #1;
        tests++;
        if (ex_rd !== 5'd3) begin fails++; $display("FAIL reset_preload ex_rd: got %0d expected 3", ex_rd); end
        #2 rst_n = 1'b0; #1;
        tests++;
        if ({ex_rd, ex_reg_write, ex_reg_dest, ex_mem_read} !== 8'd0) begin
            fails++; $display("FAIL reset_ctrl: got rd=%0d rw=%b rdst=%b mr=%b expected all 0", ex_rd, ex_reg_write, ex_reg_dest, ex_mem_read);
        end
        tests++;
        if ({ex_rs_data, ex_pc_plus4} !== 64'd0) begin
            fails++; $display("FAIL reset_data: got rs_data=%h pc4=%h expected 0", ex_rs_data, ex_pc_plus4);
        end
        tests++;
        if (stall_count !== '0) begin fails++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
        tests++;
        if ({pc_write, if_id_write, ctrl_enable} !== 3'b111) begin
            fails++; $display("FAIL reset_enables: got %b expected 111", {pc_write, if_id_write, ctrl_enable});
        end
        @(negedge clk) rst_n = 1'b1;
        $display("[TB] test_reset done");
    endtask

    task automatic test_pass_through;
        @(negedge clk);
        set_rtype(5'd1, 5'd2, 5'd3);
        id_rs_data = 32'h11; id_rt_data = 32'h22; id_pc_plus4 = 32'h104;
        #1;
        tests++;
        if ({pc_write, if_id_write, ctrl_enable} !== 3'b111) begin
            fails++; $display("FAIL pass_no_stall: got %b expected 111", {pc_write, if_id_write, ctrl_enable});
        end
        @(posedge clk); #1;
        tests++;
        if ({ex_rd, ex_reg_write, ex_reg_dest, ex_alu_op, ex_mem_read} !== {5'd3, 1'b1, 1'b1, 4'b0000, 1'b0}) begin
            fails++; $display("FAIL pass_ctrl: got rd=%0d rw=%b rdst=%b op=%b mr=%b expected rd=3 rw=1 rdst=1 op=0000 mr=0", ex_rd, ex_reg_write, ex_reg_dest, ex_alu_op, ex_mem_read);
        end
        tests++;
        if ({ex_rs_data, ex_rt_data, ex_pc_plus4, ex_funct} !== {32'h11, 32'h22, 32'h104, 6'h20}) begin
            fails++; $display("FAIL pass_data: got rs=%h rt=%h pc4=%h funct=%h expected 11 22 104 20", ex_rs_data, ex_rt_data, ex_pc_plus4, ex_funct);
        end
        $display("[TB] test_pass_through done");
    endtask

    task automatic test_load_use_rs;
        @(negedge clk);
        set_lw(5'd1, 5'd5);
        @(posedge clk);
        @(negedge clk);
        set_rtype(5'd5, 5'd2, 5'd6);
        #1;
        tests++;
        if ({pc_write, if_id_write, ctrl_enable} !== 3'b000) begin
            fails++; $display("FAIL lu_rs_stall: got %b expected 000", {pc_write, if_id_write, ctrl_enable});
        end
        @(posedge clk); #1;
        tests++;
        if ({ex_reg_write, ex_mem_read, stall_count} !== {1'b0, 1'b0, 4'd1}) begin
            fails++; $display("FAIL lu_rs_bubble: got rw=%b mr=%b cnt=%0d expected rw=0 mr=0 cnt=1", ex_reg_write, ex_mem_read, stall_count);
        end
        @(negedge clk); #1;
        tests++;
        if (pc_write !== 1'b1) begin fails++; $display("FAIL lu_rs_release: got pc_write=%b expected 1", pc_write); end
        @(posedge clk); #1;
        tests++;
        if ({ex_rd, ex_reg_write, stall_count} !== {5'd6, 1'b1, 4'd1}) begin
            fails++; $display("FAIL lu_rs_advance: got rd=%0d rw=%b cnt=%0d expected rd=6 rw=1 cnt=1", ex_rd, ex_reg_write, stall_count);
        end
        $display("[TB] test_load_use_rs done");
    endtask

    task automatic test_rt_filter;
        @(negedge clk);
        set_lw(5'd2, 5'd5);
        @(posedge clk);
        @(negedge clk);
        clear_id; id_rs = 5'd2; id_rt = 5'd5; id_alu_src = 1'b1; id_reg_write = 1'b1; id_alu_op = 4'b1000;
        #1;
        tests++;
        if (pc_write !== 1'b1) begin fails++; $display("FAIL rt_addi_no_stall: got pc_write=%b expected 1", pc_write); end
        clear_id; id_rs = 5'd2; id_rt = 5'd5; id_alu_src = 1'b1; id_mem_write = 1'b1; id_alu_op = 4'b0111;
        #1;
        tests++;
        if (if_id_write !== 1'b0) begin fails++; $display("FAIL rt_sw_stall: got if_id_write=%b expected 0", if_id_write); end
        set_rtype(5'd2, 5'd5, 5'd7);
        #1;
        tests++;
        if (ctrl_enable !== 1'b0) begin fails++; $display("FAIL rt_rtype_stall: got ctrl_enable=%b expected 0", ctrl_enable); end
        @(posedge clk); #1;
        tests++;
        if ({ex_reg_write, stall_count} !== {1'b0, 4'd2}) begin
            fails++; $display("FAIL rt_bubble: got rw=%b cnt=%0d expected rw=0 cnt=2", ex_reg_write, stall_count);
        end
        @(negedge clk);
        set_lw(5'd2, 5'd0);
        @(posedge clk); #1;
        tests++;
        if ({ex_mem_read, ex_rt} !== {1'b1, 5'd0}) begin
            fails++; $display("FAIL rt_lw_r0_load: got mr=%b rt=%0d expected mr=1 rt=0", ex_mem_read, ex_rt);
        end
        @(negedge clk);
        set_rtype(5'd0, 5'd0, 5'd9);
        #1;
        tests++;
        if (pc_write !== 1'b1) begin fails++; $display("FAIL rt_lw_r0_no_stall: got pc_write=%b expected 1", pc_write); end
        @(posedge clk);
        $display("[TB] test_rt_filter done");
    endtask

    task automatic test_flush;
        @(negedge clk);
        set_lw(5'd2, 5'd5);
        @(posedge clk);
        @(negedge clk);
        set_rtype(5'd5, 5'd2, 5'd6);
        flush = 1'b1;
        #1;
        tests++;
        if (pc_write !== 1'b0) begin fails++; $display("FAIL flush_hazard_stall: got pc_write=%b expected 0", pc_write); end
        @(posedge clk); #1;
        tests++;
        if ({ex_reg_write, ex_mem_read, stall_count} !== {1'b0, 1'b0, 4'd2}) begin
            fails++; $display("FAIL flush_hazard_count: got rw=%b mr=%b cnt=%0d expected rw=0 mr=0 cnt=2", ex_reg_write, ex_mem_read, stall_count);
        end
        @(negedge clk);
        clear_id; id_branch = 1'b1; id_is_beq = 1'b1; id_alu_op = 4'b0001; id_rs = 5'd1; id_rt = 5'd2;
        #1;
        tests++;
        if (pc_write !== 1'b1) begin fails++; $display("FAIL flush_only_enables: got pc_write=%b expected 1", pc_write); end
        @(posedge clk); #1;
        tests++;
        if ({ex_branch, ex_is_beq, ex_alu_op, stall_count} !== {1'b0, 1'b0, 4'b0000, 4'd2}) begin
            fails++; $display("FAIL flush_beq: got br=%b beq=%b op=%b cnt=%0d expected br=0 beq=0 op=0000 cnt=2", ex_branch, ex_is_beq, ex_alu_op, stall_count);
        end
        @(negedge clk) flush = 1'b0;
        $display("[TB] test_flush done");
    endtask

    task automatic test_back_to_back;
        set_lw(5'd2, 5'd5);
        @(posedge clk);
        @(negedge clk);
        set_lw(5'd5, 5'd5);
        #1;
        tests++;
        if (pc_write !== 1'b0) begin fails++; $display("FAIL b2b_first_stall: got pc_write=%b expected 0", pc_write); end
        @(posedge clk); #1;
        tests++;
        if ({ex_mem_read, stall_count} !== {1'b0, 4'd3}) begin
            fails++; $display("FAIL b2b_first_bubble: got mr=%b cnt=%0d expected mr=0 cnt=3", ex_mem_read, stall_count);
        end
        @(posedge clk); #1;
        tests++;
        if ({ex_mem_read, ex_rt} !== {1'b1, 5'd5}) begin
            fails++; $display("FAIL b2b_second_load: got mr=%b rt=%0d expected mr=1 rt=5", ex_mem_read, ex_rt);
        end
        @(negedge clk);
        set_rtype(5'd5, 5'd2, 5'd8);
        #1;
        tests++;
        if (pc_write !== 1'b0) begin fails++; $display("FAIL b2b_second_stall: got pc_write=%b expected 0", pc_write); end
        @(posedge clk); #1;
        tests++;
        if (stall_count !== 4'd4) begin fails++; $display("FAIL b2b_second_count: got %0d expected 4", stall_count); end
        @(posedge clk); #1;
        tests++;
        if ({ex_rd, ex_reg_write} !== {5'd8, 1'b1}) begin
            fails++; $display("FAIL b2b_advance: got rd=%0d rw=%b expected rd=8 rw=1", ex_rd, ex_reg_write);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_halt;
        @(negedge clk);
        set_rtype(5'd1, 5'd2, 5'd3);
        @(posedge clk);
        @(negedge clk);
        halt = 1'b1;
        set_rtype(5'd1, 5'd2, 5'd7);
        #1;
        tests++;
        if ({pc_write, if_id_write, ctrl_enable} !== 3'b000) begin
            fails++; $display("FAIL halt_enables: got %b expected 000", {pc_write, if_id_write, ctrl_enable});
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({ex_rd, ex_reg_write, stall_count} !== {5'd3, 1'b1, 4'd4}) begin
            fails++; $display("FAIL halt_frozen: got rd=%0d rw=%b cnt=%0d expected rd=3 rw=1 cnt=4", ex_rd, ex_reg_write, stall_count);
        end
        @(negedge clk);
        halt = 1'b0;
        #1;
        tests++;
        if (pc_write !== 1'b1) begin fails++; $display("FAIL halt_release: got pc_write=%b expected 1", pc_write); end
        @(posedge clk); #1;
        tests++;
        if (ex_rd !== 5'd7) begin fails++; $display("FAIL halt_resume: got rd=%0d expected 7", ex_rd); end
        $display("[TB] test_halt done");
    endtask

    task automatic test_saturation;
        // A load reading its own destination stalls every other cycle.
        @(negedge clk);
        set_lw(5'd5, 5'd5);
        repeat (22) @(posedge clk);
        #1;
        tests++;
        if (stall_count !== 4'hF) begin fails++; $display("FAIL sat_reach: got %0d expected 15", stall_count); end
        repeat (18) @(posedge clk);
        #1;
        tests++;
        if (stall_count !== 4'hF) begin fails++; $display("FAIL sat_hold: got %0d expected 15", stall_count); end
        $display("[TB] test_saturation done");
    endtask

    task automatic test_reset_mid_stall;
        @(negedge clk);
        set_lw(5'd2, 5'd5);
        @(posedge clk);
        @(negedge clk);
        set_rtype(5'd5, 5'd2, 5'd6);
        #1;
        tests++;
        if (pc_write !== 1'b0) begin fails++; $display("FAIL rms_stall: got pc_write=%b expected 0", pc_write); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({pc_write, ex_mem_read, stall_count} !== {1'b1, 1'b0, 4'd0}) begin
            fails++; $display("FAIL rms_cleared: got pcw=%b mr=%b cnt=%0d expected pcw=1 mr=0 cnt=0", pc_write, ex_mem_read, stall_count);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({ex_rd, ex_reg_write, stall_count} !== {5'd6, 1'b1, 4'd0}) begin
            fails++; $display("FAIL rms_proceed: got rd=%0d rw=%b cnt=%0d expected rd=6 rw=1 cnt=0", ex_rd, ex_reg_write, stall_count);
        end
        $display("[TB] test_reset_mid_stall done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; halt = 1'b0; flush = 1'b0;
        clear_id;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset;
        test_pass_through;
        test_load_use_rs;
        test_rt_filter;
        test_flush;
        test_back_to_back;
        test_halt;
        test_saturation;
        test_reset_mid_stall;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
